frame_buffer_pingpong: RTL and testbench

//  Downstream of the ray-flattening stage. Takes (address, pixel, last) ray writes into a back bank.

---
 rtl/frame_buffer_pingpong.sv | 140 ++++++++++++++
 tb/tb_frame_buffer_pingpong.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_pingpong.sv
// Ping-pong frame buffer: ray writes fill the back bank, the front bank is scanned out at 4x upscale.
// Optional statistics counters (swap count, dropped writes) are enabled with `define FB_STATS_EN.
module frame_buffer_pingpong #(
  parameter int PIXEL_WIDTH        = 16,
  parameter int SCREEN_WIDTH       = 320,
  parameter int SCREEN_HEIGHT      = 180,
  parameter int FULL_SCREEN_WIDTH  = 1280,
  parameter int FULL_SCREEN_HEIGHT = 720,
  parameter int SCALE_SHIFT        = 2
) (
  input  logic                   pixel_clk_in,
  input  logic                   rst_n_in,
  input  logic                   ray_valid_in,
  input  logic [15:0]            ray_address_in,
  input  logic [PIXEL_WIDTH-1:0] ray_pixel_in,
  input  logic                   ray_last_pixel_in,
  output logic                   fb_ready_out,
  input  logic [10:0]            hcount_in,
  input  logic [9:0]             vcount_in,
  input  logic                   new_frame_in,
  output logic [PIXEL_WIDTH-1:0] pixel_out,
  output logic                   front_bank_out
`ifdef FB_STATS_EN
  ,
  output logic [15:0]            frames_swapped_out,
  output logic [15:0]            dropped_writes_out
`endif
);

  localparam int          FB_DEPTH   = SCREEN_WIDTH * SCREEN_HEIGHT;
  localparam logic [15:0] FB_DEPTH_W = 16'(FB_DEPTH);
  localparam logic [10:0] FULL_W     = 11'(FULL_SCREEN_WIDTH);
  localparam logic [9:0]  FULL_H     = 10'(FULL_SCREEN_HEIGHT);

  typedef enum logic {WRITING, WAIT_SWAP} state_t;

  state_t state;

  logic addr_ok;
  logic wr_en;
  logic swap;

  assign fb_ready_out = (state == WRITING);
  assign addr_ok      = (ray_address_in < FB_DEPTH_W);
  assign wr_en        = ray_valid_in && fb_ready_out && addr_ok;
  assign swap         = (state == WAIT_SWAP) && new_frame_in;

  // A last write always parks in WAIT_SWAP, even if new_frame_in coincides; only a later pulse swaps.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state          <= WRITING;
      front_bank_out <= 1'b0;
    end else begin
      case (state)
        WRITING: begin
          if (wr_en && ray_last_pixel_in) state <= WAIT_SWAP;
        end
        WAIT_SWAP: begin
          if (new_frame_in) begin
            front_bank_out <= ~front_bank_out;
            state          <= WRITING;
          end
        end
        default: state <= WRITING;
      endcase
    end
  end

`ifdef FB_STATS_EN
  logic drop;

  assign drop = ray_valid_in && !wr_en;

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      frames_swapped_out <= '0;
      dropped_writes_out <= '0;
    end else begin
      if (swap) frames_swapped_out <= frames_swapped_out + 16'd1;
      if (drop) dropped_writes_out <= dropped_writes_out + 16'd1;
    end
  end
`endif

  // c0: display coordinate -> frame-buffer address, blanking flag and bank select
  logic [10:0] fb_x_c0;
  logic [9:0]  fb_y_c0;
  logic [16:0] addr_c0;
  logic        active_c0;

  assign fb_x_c0   = hcount_in >> SCALE_SHIFT;
  assign fb_y_c0   = vcount_in >> SCALE_SHIFT;
  assign addr_c0   = 17'(fb_y_c0) * 17'(SCREEN_WIDTH) + 17'(fb_x_c0);
  assign active_c0 = (hcount_in < FULL_W) && (vcount_in < FULL_H);

  logic [15:0] rd_addr_p0;
  logic        vld_p0;
  logic        bank_p0;
  logic        vld_p1;
  logic        bank_p1;

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld_p0  <= 1'b0;
      bank_p0 <= 1'b0;
      vld_p1  <= 1'b0;
      bank_p1 <= 1'b0;
    end else begin
      vld_p0  <= active_c0;
      bank_p0 <= front_bank_out;
      vld_p1  <= vld_p0;
      bank_p1 <= bank_p0;
    end
  end

  // Blanked coordinates read address 0 so the BRAM index never leaves the bank.
  always_ff @(posedge pixel_clk_in) begin
    rd_addr_p0 <= active_c0 ? addr_c0[15:0] : 16'd0;
  end

  // c1: synchronous BRAM reads; the write port targets the back bank (~front_bank_out)
  logic [PIXEL_WIDTH-1:0] bank0_mem [FB_DEPTH];
  logic [PIXEL_WIDTH-1:0] bank1_mem [FB_DEPTH];
  logic [PIXEL_WIDTH-1:0] rd0_p1;
  logic [PIXEL_WIDTH-1:0] rd1_p1;

  always_ff @(posedge pixel_clk_in) begin
    if (wr_en && front_bank_out) bank0_mem[ray_address_in] <= ray_pixel_in;
    rd0_p1 <= bank0_mem[rd_addr_p0];
  end

  always_ff @(posedge pixel_clk_in) begin
    if (wr_en && !front_bank_out) bank1_mem[ray_address_in] <= ray_pixel_in;
    rd1_p1 <= bank1_mem[rd_addr_p0];
  end

  // c2: bank select captured at c0 keeps each pixel within one bank across a swap
  assign pixel_out = vld_p1 ? (bank_p1 ? rd1_p1 : rd0_p1) : '0;

endmodule

// File: tb/tb_frame_buffer_pingpong.sv
// Scoreboard bench for frame_buffer_pingpong: reads push expected pixels, a monitor pops them.
module tb_frame_buffer_pingpong;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ray_valid = 1'b0;
  logic [15:0] ray_address = '0;
  logic [15:0] ray_pixel = '0;
  logic        ray_last = 1'b0;
  logic        fb_ready;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic        new_frame = 1'b0;
  logic [15:0] pixel;
  logic        front_bank;
`ifdef FB_STATS_EN
  logic [15:0] frames_swapped;
  logic [15:0] dropped_writes;
`endif

  frame_buffer_pingpong dut (
    .pixel_clk_in      (clk),
    .rst_n_in          (rst_n),
    .ray_valid_in      (ray_valid),
    .ray_address_in    (ray_address),
    .ray_pixel_in      (ray_pixel),
    .ray_last_pixel_in (ray_last),
    .fb_ready_out      (fb_ready),
    .hcount_in         (hcount),
    .vcount_in         (vcount),
    .new_frame_in      (new_frame),
    .pixel_out         (pixel),
    .front_bank_out    (front_bank)
`ifdef FB_STATS_EN
    ,
    .frames_swapped_out(frames_swapped),
    .dropped_writes_out(dropped_writes)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [10:0] h;
    logic [9:0]  v;
    logic [15:0] exp;
  } rd_t;

  rd_t exp_q[$];
  logic rd_req = 1'b0;
  logic req_d1 = 1'b0;
  logic req_d2 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a read request surfaces on pixel_out two edges after it was sampled.
  always @(posedge clk) begin
    req_d1 <= rd_req;
    req_d2 <= req_d1;
  end

  always @(negedge clk) begin
    if (req_d2) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pixel: output with empty scoreboard at %0t", $time);
      end else begin
        rd_t e;
        e = exp_q.pop_front();
        chk($sformatf("pixel h=%0d v=%0d", e.h, e.v), 32'(pixel), 32'(e.exp));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    ray_valid = 1'b0;
    ray_last  = 1'b0;
    new_frame = 1'b0;
    rd_req    = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] p, input logic l, input logic nf);
    step();
    ray_valid   = 1'b1;
    ray_address = a;
    ray_pixel   = p;
    ray_last    = l;
    new_frame   = nf;
  endtask

  task automatic pulse_frame();
    step();
    new_frame = 1'b1;
  endtask

  task automatic rd(input logic [10:0] h, input logic [9:0] v, input logic [15:0] e);
    rd_t r;
    step();
    hcount = h;
    vcount = v;
    rd_req = 1'b1;
    r.h = h; r.v = v; r.exp = e;
    exp_q.push_back(r);
  endtask

  task automatic drain();
    repeat (4) step();
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded cycle budget");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset, checked while rst_n is still low
    #2;
    chk("reset front_bank", 32'(front_bank), 32'd0);
    chk("reset fb_ready", 32'(fb_ready), 32'd1);
    chk("reset pixel_out", 32'(pixel), 32'd0);
    #20 rst_n = 1'b1;

    // Fill back bank 1 with pixel == address
    for (int i = 0; i < 57600; i++)
      wr(16'(i), 16'(i), (i == 57599), 1'b0);
    step();
    chk("ready after last", 32'(fb_ready), 32'd0);
    chk("no swap before frame", 32'(front_bank), 32'd0);
    wr(16'd5, 16'hBEEF, 1'b0, 1'b0);
    pulse_frame();
    step();
    chk("front after swap", 32'(front_bank), 32'd1);
    chk("ready after swap", 32'(fb_ready), 32'd1);

    rd(11'd8, 10'd4, 16'd322);
    rd(11'd20, 10'd0, 16'd5);
    for (int v = 0; v < 4; v++)
      for (int h = 0; h < 4; h++)
        rd(11'(h), 10'(v), 16'd0);
    rd(11'd4, 10'd0, 16'd1);
    rd(11'd1279, 10'd719, 16'd57599);
    rd(11'd1280, 10'd0, 16'd0);
    rd(11'd0, 10'd720, 16'd0);
    rd(11'd2047, 10'd1023, 16'd0);
    drain();

    // Out-of-range last write is dropped and does not end the sweep
    wr(16'd60000, 16'hDEAD, 1'b1, 1'b0);
    step();
    chk("ready after bad addr", 32'(fb_ready), 32'd1);

    // Last write coincident with new_frame: no swap yet
    wr(16'd0, 16'h1111, 1'b0, 1'b0);
    wr(16'd1, 16'h2222, 1'b0, 1'b0);
    wr(16'd2, 16'h3333, 1'b1, 1'b1);
    step();
    chk("coincident no swap", 32'(front_bank), 32'd1);
    chk("coincident ready", 32'(fb_ready), 32'd0);
    rd(11'd0, 10'd0, 16'd0);
    rd(11'd8, 10'd0, 16'd2);
    drain();
    pulse_frame();
    step();
    chk("front after 2nd swap", 32'(front_bank), 32'd0);
    rd(11'd0, 10'd0, 16'h1111);
    rd(11'd4, 10'd0, 16'h2222);
    rd(11'd8, 10'd0, 16'h3333);
    rd(11'd11, 10'd3, 16'h3333);
    drain();
`ifdef FB_STATS_EN
    chk("dropped_writes", 32'(dropped_writes), 32'd2);
    chk("frames_swapped", 32'(frames_swapped), 32'd2);
`endif

    // Third sweep into bank 1, swap, then park in WAIT_SWAP with front=1
    wr(16'd3, 16'h4444, 1'b1, 1'b0);
    step();
    chk("ready 3rd sweep", 32'(fb_ready), 32'd0);
    pulse_frame();
    step();
    chk("front after 3rd swap", 32'(front_bank), 32'd1);
    wr(16'd4, 16'h5555, 1'b1, 1'b0);
    step();
    hcount = 11'd8;
    vcount = 10'd0;
    step();
    step();
    step();
    chk("held read before reset", 32'(pixel), 32'd2);
    chk("ready before reset", 32'(fb_ready), 32'd0);
`ifdef FB_STATS_EN
    chk("frames_swapped 3", 32'(frames_swapped), 32'd3);
`endif

    // Asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    chk("async reset front", 32'(front_bank), 32'd0);
    chk("async reset ready", 32'(fb_ready), 32'd1);
    chk("async reset pixel", 32'(pixel), 32'd0);
`ifdef FB_STATS_EN
    chk("async reset frames", 32'(frames_swapped), 32'd0);
    chk("async reset dropped", 32'(dropped_writes), 32'd0);
`endif
    #10 rst_n = 1'b1;
    step();
    chk("scoreboard empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
